interleave_sequencer: RTL and testbench

Streaming controller that wraps the 2-bit symbol interleave. It accepts a byte stream under valid/ready handshake, groups every four bytes into a block, and emits the four interleaved bytes one per cycle. Two ping-pong banks give a sustained one-byte-per-cycle rate. Short final blocks are padded, and a per-block bypass is supported. It sits between the framing/FEC byte source and the symbol mapper in the transmit path, and mirrors the receiver's de-interleave stage.

---
 rtl/interleave_sequencer.sv | 122 ++++++++++++
 tb/tb_interleave_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/interleave_sequencer.sv
// Ping-pong 4-byte block buffer that emits each block as 2-bit symbol
// interleaved bytes (or unchanged when the block is marked bypass).
module interleave_sequencer #(
    parameter logic [7:0] PAD_BYTE = 8'h00,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic             cfg_bypass,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [CNT_W-1:0] blk_cnt
);

    logic [1:0][3:0][7:0] r_mem,      w_mem_nxt;
    logic [1:0]           r_full,     w_full_nxt;
    logic [1:0]           r_last,     w_last_nxt;
    logic [1:0]           r_byp,      w_byp_nxt;
    logic                 r_wr_bank,  w_wr_bank_nxt;
    logic [1:0]           r_wr_idx,   w_wr_idx_nxt;
    logic                 r_rd_bank,  w_rd_bank_nxt;
    logic [1:0]           r_rd_idx,   w_rd_idx_nxt;
    logic [CNT_W-1:0]     r_blk_cnt,  w_blk_cnt_nxt;

    logic                 w_in_xfer;
    logic                 w_out_xfer;
    logic [3:0][7:0]      w_rd_blk;
    logic [7:0]           w_ilv;

    assign w_in_xfer  = in_valid && !r_full[r_wr_bank];
    assign w_out_xfer = r_full[r_rd_bank] && out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem     <= '0;
            r_full    <= '0;
            r_last    <= '0;
            r_byp     <= '0;
            r_wr_bank <= 1'b0;
            r_wr_idx  <= 2'd0;
            r_rd_bank <= 1'b0;
            r_rd_idx  <= 2'd0;
            r_blk_cnt <= '0;
        end else begin
            r_mem     <= w_mem_nxt;
            r_full    <= w_full_nxt;
            r_last    <= w_last_nxt;
            r_byp     <= w_byp_nxt;
            r_wr_bank <= w_wr_bank_nxt;
            r_wr_idx  <= w_wr_idx_nxt;
            r_rd_bank <= w_rd_bank_nxt;
            r_rd_idx  <= w_rd_idx_nxt;
            r_blk_cnt <= w_blk_cnt_nxt;
        end
    end

    // Next state. A write only targets an empty bank and a read only a full
    // one, so the fill and drain sides never touch the same bank in a cycle.
    always_comb begin
        w_mem_nxt     = r_mem;
        w_full_nxt    = r_full;
        w_last_nxt    = r_last;
        w_byp_nxt     = r_byp;
        w_wr_bank_nxt = r_wr_bank;
        w_wr_idx_nxt  = r_wr_idx;
        w_rd_bank_nxt = r_rd_bank;
        w_rd_idx_nxt  = r_rd_idx;
        w_blk_cnt_nxt = r_blk_cnt;

        if (w_in_xfer) begin
            w_mem_nxt[r_wr_bank][r_wr_idx] = in_data;
            if (r_wr_idx == 2'd0)
                w_byp_nxt[r_wr_bank] = cfg_bypass;
            if (r_wr_idx == 2'd3 || in_last) begin
                for (int s = 0; s < 4; s++)
                    if (2'(s) > r_wr_idx)
                        w_mem_nxt[r_wr_bank][2'(s)] = PAD_BYTE;
                w_last_nxt[r_wr_bank] = in_last;
                w_full_nxt[r_wr_bank] = 1'b1;
                w_wr_bank_nxt         = !r_wr_bank;
                w_wr_idx_nxt          = 2'd0;
            end else begin
                w_wr_idx_nxt = r_wr_idx + 2'd1;
            end
        end

        if (w_out_xfer) begin
            if (r_rd_idx == 2'd3) begin
                w_full_nxt[r_rd_bank] = 1'b0;
                w_rd_bank_nxt         = !r_rd_bank;
                w_rd_idx_nxt          = 2'd0;
                w_blk_cnt_nxt         = r_blk_cnt + CNT_W'(1);
            end else begin
                w_rd_idx_nxt = r_rd_idx + 2'd1;
            end
        end
    end

    // Outputs depend only on registered state.
    always_comb begin
        w_rd_blk = r_mem[r_rd_bank];
        w_ilv    = '0;
        for (int j = 0; j < 4; j++)
            w_ilv[2*j +: 2] = w_rd_blk[j][{r_rd_idx, 1'b0} +: 2];

        in_ready  = !r_full[r_wr_bank];
        out_valid = r_full[r_rd_bank];
        out_data  = 8'h00;
        if (r_full[r_rd_bank])
            out_data = r_byp[r_rd_bank] ? w_rd_blk[r_rd_idx] : w_ilv;
        out_last  = r_full[r_rd_bank] && (r_rd_idx == 2'd3) && r_last[r_rd_bank];
        blk_cnt   = r_blk_cnt;
    end

endmodule

// File: tb/tb_interleave_sequencer.sv
// Randomized bench for interleave_sequencer against a queue-based block model.
module tb_interleave_sequencer;

    localparam int CW = 4;  // narrow counter so the wrap is reachable

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic          cfg_bypass;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [CW-1:0] blk_cnt;

    interleave_sequencer #(.PAD_BYTE(8'h00), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .cfg_bypass(cfg_bypass),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .blk_cnt(blk_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: expected output stream as {last, data}, plus the block being filled.
    logic [8:0] exp_q[$];
    logic [7:0] cur[$];
    logic       cur_byp;
    int         n_emit;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] mix(input logic [7:0] b[4], input int k, input logic byp);
        int o;
        if (byp) return b[k];
        o = 0;
        for (int j = 0; j < 4; j++)
            o += ((int'(b[j]) >> (2*k)) & 3) << (2*j);
        return 8'(o);
    endfunction

    function automatic logic m_in_ready();
        return ((exp_q.size() + 3) / 4) < 2;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        cur.delete();
        cur_byp = 1'b0;
        n_emit  = 0;
    endtask

    task automatic check_outputs();
        chk("in_ready",  {31'd0, in_ready},  {31'd0, m_in_ready()});
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
        chk("out_data",  {24'd0, out_data},  exp_q.size() > 0 ? {24'd0, exp_q[0][7:0]} : 32'd0);
        chk("out_last",  {31'd0, out_last},  exp_q.size() > 0 ? {31'd0, exp_q[0][8]} : 32'd0);
        chk("blk_cnt",   {28'd0, blk_cnt},   32'((n_emit / 4) % (1 << CW)));
    endtask

    // Drive one cycle of inputs, advance the model, then check at the next negedge.
    task automatic tick(input logic v, input logic [7:0] d, input logic l,
                        input logic b, input logic ordy, output logic acc);
        logic [7:0] blk[4];
        in_valid = v; in_data = d; in_last = l; cfg_bypass = b; out_ready = ordy;
        acc = v && m_in_ready();
        if (exp_q.size() > 0 && ordy) begin
            void'(exp_q.pop_front());
            n_emit++;
        end
        if (acc) begin
            if (cur.size() == 0) cur_byp = b;
            cur.push_back(d);
            if (cur.size() == 4 || l) begin
                while (cur.size() < 4) cur.push_back(8'h00);
                for (int k = 0; k < 4; k++) blk[k] = cur[k];
                for (int k = 0; k < 4; k++)
                    exp_q.push_back({(k == 3) && l, mix(blk, k, cur_byp)});
                cur.delete();
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send(input logic [7:0] d, input logic l, input logic b);
        logic acc;
        for (int i = 0; i < 50; i++) begin
            tick(1'b1, d, l, b, 1'b1, acc);
            if (acc) return;
        end
        chk("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) return;
            tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
        end
        chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; cfg_bypass = 1'b0; out_ready = 1'b0;
    endtask

    task automatic reset_now();
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic acc;
        logic [7:0] bp[12];
        int idx;
        int bp_stall;

        idle_inputs();
        model_clear();
        rst_n = 1'b0;
        #12;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Single block, interleaved
        send(8'h1B, 1'b0, 1'b0);
        send(8'h2E, 1'b0, 1'b0);
        send(8'h93, 1'b0, 1'b0);
        send(8'hC4, 1'b0, 1'b0);
        drain();

        // Sustained back-to-back stream (counter wraps on the way)
        for (int i = 0; i < 64; i++)
            send(8'($urandom), 1'b0, 1'($urandom));
        drain();

        // Short frame padded out
        send(8'hFF, 1'b0, 1'b0);
        send(8'hFF, 1'b0, 1'b0);
        send(8'hFF, 1'b1, 1'b0);
        drain();
        send(8'h5A, 1'b0, 1'b0);
        send(8'hA5, 1'b0, 1'b0);
        send(8'h3C, 1'b0, 1'b0);
        send(8'hC3, 1'b1, 1'b0);
        drain();

        // Backpressure: 12 offered with out_ready low, only two blocks fit
        for (int i = 0; i < 12; i++) bp[i] = 8'($urandom);
        idx = 0;
        for (int i = 0; i < 20; i++) begin
            tick(idx < 12, idx < 12 ? bp[idx] : 8'h00, 1'b0, 1'b0, 1'b0, acc);
            if (acc) idx++;
        end
        chk("bp_accepted", 32'(idx), 32'd8);
        bp_stall = 0;
        while (idx < 12 && bp_stall < 50) begin
            tick(1'b1, bp[idx], 1'b0, 1'b0, 1'b1, acc);
            if (acc) idx++;
            bp_stall++;
        end
        chk("bp_all_sent", 32'(idx), 32'd12);
        drain();

        // Bypass latched on first byte only
        send(8'h12, 1'b0, 1'b1);
        send(8'h34, 1'b0, 1'b0);
        send(8'h56, 1'b0, 1'b1);
        send(8'h78, 1'b0, 1'b0);
        send(8'h9A, 1'b0, 1'b0);
        send(8'hBC, 1'b0, 1'b1);
        send(8'hDE, 1'b0, 1'b1);
        send(8'hF0, 1'b0, 1'b1);
        drain();

        // Random traffic
        for (int i = 0; i < 400; i++)
            tick(1'($urandom_range(0, 3) != 0), 8'($urandom), $urandom_range(0, 7) == 0,
                 1'($urandom), $urandom_range(0, 3) != 0, acc);
        drain();

        // Reset with one bank full and one half filled
        for (int i = 0; i < 6; i++)
            tick(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, acc);
        chk("pre_reset_pending", 32'(exp_q.size()), 32'd4);
        reset_now();
        for (int i = 0; i < 3; i++)
            tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
        send(8'hE4, 1'b0, 1'b0);
        send(8'h1B, 1'b0, 1'b0);
        send(8'h72, 1'b0, 1'b0);
        send(8'h8D, 1'b1, 1'b0);
        drain();
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
        chk("blk_after_reset", {28'd0, blk_cnt}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
